// File: rtl/oversampled_serializer_tx.sv
// 4x-oversampling serializer: bytes go out MSB-first, 2 bits per clk, as 8-sample words.
// Optional PRBS7 test source is built only when OSTX_PRBS_EN is defined.
module oversampled_serializer_tx #(
  parameter logic [7:0] IDLE_BYTE = 8'h55
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic [1:0] phase_i,
  input  logic       test_mode_i,
  output logic [7:0] sample_window_o,
  output logic       byte_start_o,
  output logic       underrun_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] pair_cnt_q, pair_cnt_d;
  logic [5:0] shift_q, shift_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] window_q, window_d;
  logic       byte_start_q, byte_start_d;
  logic       underrun_q, underrun_d;

  logic       boundary_s;
  logic       prbs_sel_s;
  logic       handshake_s;
  logic [7:0] prbs_byte_s;
  logic [7:0] byte_s;
  logic [1:0] pair_s;
  logic [7:0] raw_s;

  // Pair {a,b}, a first in time, lands in the low (earlier) samples.
  function automatic logic [7:0] build_raw(input logic [1:0] pair);
    return {{4{pair[0]}}, {4{pair[1]}}};
  endfunction

  function automatic logic [7:0] apply_phase(input logic [7:0] raw, input logic [7:0] prev,
                                             input logic [1:0] p);
    logic [15:0] cat;
    cat = {raw, prev} >> (4'd8 - {2'b00, p});
    return cat[7:0];
  endfunction

  assign boundary_s  = (pair_cnt_q == 2'd3);
  assign s_ready_o   = boundary_s && !reset_i && !prbs_sel_s;
  assign handshake_s = s_ready_o && s_valid_i;

`ifdef OSTX_PRBS_EN
  logic [6:0]  lfsr_q;
  logic [14:0] prbs_step_s;

  // Eight PRBS7 (x^7+x^6+1) steps per byte; the first generated bit becomes b7.
  function automatic logic [14:0] prbs7_byte(input logic [6:0] seed);
    logic [6:0] l;
    logic [7:0] b;
    logic       fb;
    l = seed;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb       = l[6] ^ l[5];
      b[7 - i] = fb;
      l        = {l[5:0], fb};
    end
    return {l, b};
  endfunction

  assign prbs_step_s = prbs7_byte(lfsr_q);
  assign prbs_byte_s = prbs_step_s[7:0];
  assign prbs_sel_s  = boundary_s && test_mode_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= 7'h7F;
    end else if (prbs_sel_s) begin
      lfsr_q <= prbs_step_s[14:8];
    end else begin
      lfsr_q <= lfsr_q;
    end
  end
`else
  logic unused_test_mode_s;
  assign unused_test_mode_s = test_mode_i;
  assign prbs_byte_s        = IDLE_BYTE;
  assign prbs_sel_s         = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pair_cnt_d   = pair_cnt_q + 2'd1;
    shift_d      = {shift_q[3:0], 2'b00};
    phase_d      = phase_q;
    byte_start_d = 1'b0;
    underrun_d   = 1'b0;
    byte_s       = IDLE_BYTE;
    pair_s       = shift_q[5:4];
    if (boundary_s) begin
      byte_start_d = 1'b1;
      phase_d      = phase_i;
      pair_cnt_d   = 2'd0;
      if (prbs_sel_s) begin
        byte_s  = prbs_byte_s;
        state_d = ST_DATA;
      end else if (handshake_s) begin
        byte_s  = s_data_i;
        state_d = ST_DATA;
      end else begin
        byte_s     = IDLE_BYTE;
        state_d    = ST_IDLE;
        underrun_d = (state_q == ST_DATA);
      end
      // The first pair leaves immediately; the other three wait in the shifter.
      pair_s  = byte_s[7:6];
      shift_d = byte_s[5:0];
    end else begin
      byte_s = IDLE_BYTE;
    end
    raw_s    = build_raw(pair_s);
    prev_d   = raw_s;
    window_d = apply_phase(raw_s, prev_q, phase_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      pair_cnt_q   <= 2'd3;
      shift_q      <= 6'd0;
      phase_q      <= 2'd0;
      prev_q       <= 8'h00;
      window_q     <= 8'h00;
      byte_start_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pair_cnt_q   <= pair_cnt_d;
      shift_q      <= shift_d;
      phase_q      <= phase_d;
      prev_q       <= prev_d;
      window_q     <= window_d;
      byte_start_q <= byte_start_d;
      underrun_q   <= underrun_d;
    end
  end

  assign sample_window_o = window_q;
  assign byte_start_o    = byte_start_q;
  assign underrun_o      = underrun_q;

endmodule
